// File: rtl/shifter_pkg.sv
// Shared types and helpers for the sequential shifter.
// The rotation option (SHIFTER_SEQ_ROTATE_EN) is resolved inside shift_step.
package shifter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_DONE
   } state_e;

   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

   // Smallest r such that 2**r >= v; gives 0 for v <= 1.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/shift_step.sv
// One combinational step of the sequential shifter: moves {X,Y} by s positions.
// Macro SHIFTER_SEQ_ROTATE_EN: when defined, rot=1 wraps bits leaving X back into X instead of fill.
module shift_step
   import shifter_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int SW    = 4
) (
   input  logic [WIDTH-1:0] x_in,
   input  logic [WIDTH-1:0] y_in,
   input  logic [SW-1:0]    s,
   input  logic             dir,
   input  logic             fill,
   input  logic             rot,
   output logic [WIDTH-1:0] x_out,
   output logic [WIDTH-1:0] y_out
);

   logic [2*WIDTH-1:0] wide;
   logic [WIDTH-1:0]   mask;
   logic [WIDTH-1:0]   wrap;
   logic               use_rot;

`ifdef SHIFTER_SEQ_ROTATE_EN
   assign use_rot = rot;
`else
   logic unused_rot;
   assign unused_rot = rot;
   assign use_rot    = 1'b0;
`endif

   // Shifts by >= WIDTH yield zero, so s=0 leaves wrap empty and mask clear.
   always_comb begin
      wide  = '0;
      mask  = '0;
      wrap  = '0;
      x_out = x_in;
      y_out = y_in;
      if (dir == DIR_LEFT) begin
         wide  = {y_in, x_in} << s;
         mask  = ~({WIDTH{1'b1}} << s);
         wrap  = x_in >> (WIDTH - int'(s));
         x_out = wide[WIDTH-1:0] | (use_rot ? wrap : (fill ? mask : '0));
         y_out = wide[2*WIDTH-1:WIDTH];
      end else begin
         wide  = {x_in, y_in} >> s;
         mask  = ~({WIDTH{1'b1}} >> s);
         wrap  = x_in << (WIDTH - int'(s));
         x_out = wide[2*WIDTH-1:WIDTH] | (use_rot ? wrap : (fill ? mask : '0));
         y_out = wide[WIDTH-1:0];
      end
   end

endmodule

// File: rtl/shifter_seq.sv
// Multi-cycle shifter, up to STEP positions per clock; result after ceil(n/STEP) step edges, held in DONE until out_ready.
// Rotation is available when SHIFTER_SEQ_ROTATE_EN is defined (handled in shift_step); otherwise in_rot is ignored.
module shifter_seq
   import shifter_pkg::*;
#(
   parameter  int WIDTH = 8,
   parameter  int STEP  = 1,
   localparam int AW    = clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [AW-1:0]    in_amt,
   input  logic             in_dir,
   input  logic             in_fill,
   input  logic             in_rot,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [WIDTH-1:0] out_spill
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] x_q, x_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic [AW-1:0]    rem_q, rem_d;
   logic             dir_q, dir_d;
   logic             fill_q, fill_d;
   logic             rot_q, rot_d;

   logic [AW-1:0]    amt_clamp;
   logic [AW-1:0]    s_amt;
   logic [WIDTH-1:0] step_x;
   logic [WIDTH-1:0] step_y;

   assign amt_clamp = (in_amt > AW'(WIDTH)) ? AW'(WIDTH) : in_amt;
   assign s_amt     = (rem_q > AW'(STEP)) ? AW'(STEP) : rem_q;

   shift_step #(
      .WIDTH (WIDTH),
      .SW    (AW)
   ) u_step (
      .x_in  (x_q),
      .y_in  (y_q),
      .s     (s_amt),
      .dir   (dir_q),
      .fill  (fill_q),
      .rot   (rot_q),
      .x_out (step_x),
      .y_out (step_y)
   );

   assign in_ready  = (state_q == ST_IDLE) && rst_n;
   assign out_valid = (state_q == ST_DONE);
   assign out_data  = x_q;
   assign out_spill = y_q;

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      rem_d   = rem_q;
      dir_d   = dir_q;
      fill_d  = fill_q;
      rot_d   = rot_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid && in_ready) begin
               x_d     = in_data;
               y_d     = '0;
               rem_d   = amt_clamp;
               dir_d   = in_dir;
               fill_d  = in_fill;
               rot_d   = in_rot;
               state_d = (amt_clamp != '0) ? ST_SHIFT : ST_DONE;
            end
         end
         ST_SHIFT: begin
            x_d   = step_x;
            y_d   = step_y;
            rem_d = rem_q - s_amt;
            if (rem_d == '0) state_d = ST_DONE;
         end
         ST_DONE: begin
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         x_q     <= '0;
         y_q     <= '0;
         rem_q   <= '0;
         dir_q   <= 1'b0;
         fill_q  <= 1'b0;
         rot_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         rem_q   <= rem_d;
         dir_q   <= dir_d;
         fill_q  <= fill_d;
         rot_q   <= rot_d;
      end
   end

endmodule
